// File: rtl/fcpu_pkg.sv
// fcpu_pkg -- shared widths and types for the fcpu back end.
//   DATA_W, RSV_ID_W, REG_ADDR_W, CRAM_ADDR_W : datapath widths
//   commit_kind_t                            : kind of the ROB head entry
//   commit_t                                 : packed ROB head entry seen by commit_unit
//   cu_state_t                               : commit_unit FSM states
//   miss_target()                            : corrected fetch address of a branch entry
package fcpu_pkg;

   localparam int DATA_W      = 32;
   localparam int RSV_ID_W    = 4;
   localparam int REG_ADDR_W  = 5;
   localparam int CRAM_ADDR_W = 12;

   typedef enum logic [1:0] {
      CK_NONE   = 2'd0,
      CK_REG    = 2'd1,
      CK_BRANCH = 2'd2,
      CK_OUT    = 2'd3
   } commit_kind_t;

   typedef struct packed {
      commit_kind_t            kind;
      logic [RSV_ID_W-1:0]     rsv_id;
      logic [REG_ADDR_W-1:0]   dst_reg;
      logic [DATA_W-1:0]       data;
      logic                    pred_taken;
      logic                    act_taken;
      logic [CRAM_ADDR_W-1:0]  target;
      logic [CRAM_ADDR_W-1:0]  fallthru;
   } commit_t;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_IO_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } cu_state_t;

   // Address fetch must restart from once the real branch outcome is known.
   function automatic logic [CRAM_ADDR_W-1:0] miss_target(input commit_t c);
      return c.act_taken ? c.target : c.fallthru;
   endfunction

endpackage

// File: rtl/commit_unit.sv
// commit_unit -- retires the ROB head entry and produces its side effects.
//   clk, rst          : clock, synchronous active-high reset
//   i_valid / i_ready : head-entry handshake; accept when both are 1
//   i_commit          : head entry (commit_t)
//   reg_we, reg_wr_addr, reg_wr_data : register-file write, one-cycle pulse,
//                       data = {rsv_id, data} so the file can match the tag
//   branch_miss, pred_miss_dst       : flush request and corrected fetch address,
//                       held for FLUSH_CYCLES cycles after a misprediction
//   io_o_data, io_o_valid, io_o_ready: output byte handshake
//   retired           : count of committed entries, wraps modulo 2^CNT_W
module commit_unit
   import fcpu_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   output logic                         i_ready,
   input  commit_t                      i_commit,
   output logic                         reg_we,
   output logic [REG_ADDR_W-1:0]        reg_wr_addr,
   output logic [RSV_ID_W+DATA_W-1:0]   reg_wr_data,
   output logic                         branch_miss,
   output logic [CRAM_ADDR_W-1:0]       pred_miss_dst,
   output logic [7:0]                   io_o_data,
   output logic                         io_o_valid,
   input  logic                         io_o_ready,
   output logic [CNT_W-1:0]             retired
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

   cu_state_t                     r_state, w_state_next;
   logic                          r_reg_we, w_reg_we_next;
   logic [REG_ADDR_W-1:0]         r_reg_wr_addr, w_reg_wr_addr_next;
   logic [RSV_ID_W+DATA_W-1:0]    r_reg_wr_data, w_reg_wr_data_next;
   logic                          r_branch_miss, w_branch_miss_next;
   logic [CRAM_ADDR_W-1:0]        r_pred_miss_dst, w_pred_miss_dst_next;
   logic [7:0]                    r_io_o_data, w_io_o_data_next;
   logic                          r_io_o_valid, w_io_o_valid_next;
   logic [CNT_W-1:0]              r_retired, w_retired_next;
   logic [FC_W-1:0]               r_flush_cnt, w_flush_cnt_next;
   logic                          w_ready;
   logic                          w_accept;

   // Ready is gated by rst so nothing is accepted on a reset edge.
   assign w_ready  = (r_state == ST_RUN) && !rst;
   assign w_accept = i_valid && w_ready;

   always_comb begin
      w_state_next         = r_state;
      w_reg_we_next        = 1'b0;
      w_reg_wr_addr_next   = r_reg_wr_addr;
      w_reg_wr_data_next   = r_reg_wr_data;
      w_branch_miss_next   = r_branch_miss;
      w_pred_miss_dst_next = r_pred_miss_dst;
      w_io_o_data_next     = r_io_o_data;
      w_io_o_valid_next    = r_io_o_valid;
      w_flush_cnt_next     = r_flush_cnt;
      w_retired_next       = r_retired;

      if (w_accept) begin
         w_retired_next = r_retired + CNT_W'(1);
      end

      case (r_state)
         ST_RUN: begin
            if (w_accept) begin
               case (i_commit.kind)
                  CK_REG: begin
                     // r0 is hard-wired: the entry retires but never writes.
                     if (i_commit.dst_reg != '0) begin
                        w_reg_we_next      = 1'b1;
                        w_reg_wr_addr_next = i_commit.dst_reg;
                        w_reg_wr_data_next = {i_commit.rsv_id, i_commit.data};
                     end
                  end
                  CK_BRANCH: begin
                     if (i_commit.pred_taken != i_commit.act_taken) begin
                        w_state_next         = ST_FLUSH;
                        w_branch_miss_next   = 1'b1;
                        w_pred_miss_dst_next = miss_target(i_commit);
                        w_flush_cnt_next     = FC_W'(FLUSH_CYCLES);
                     end
                  end
                  CK_OUT: begin
                     w_state_next      = ST_IO_WAIT;
                     w_io_o_valid_next = 1'b1;
                     w_io_o_data_next  = i_commit.data[7:0];
                  end
                  default: begin
                     // CK_NONE and anything unrecognised only retire.
                  end
               endcase
            end
         end
         ST_IO_WAIT: begin
            if (io_o_ready) begin
               w_state_next      = ST_RUN;
               w_io_o_valid_next = 1'b0;
            end
         end
         ST_FLUSH: begin
            // Counter holds the cycles of flush still to present, including this one.
            if (r_flush_cnt <= FC_W'(1)) begin
               w_state_next       = ST_RUN;
               w_branch_miss_next = 1'b0;
               w_flush_cnt_next   = '0;
            end else begin
               w_flush_cnt_next = r_flush_cnt - FC_W'(1);
            end
         end
         default: begin
            w_state_next       = ST_RUN;
            w_branch_miss_next = 1'b0;
            w_io_o_valid_next  = 1'b0;
            w_flush_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_RUN;
         r_reg_we        <= 1'b0;
         r_reg_wr_addr   <= '0;
         r_reg_wr_data   <= '0;
         r_branch_miss   <= 1'b0;
         r_pred_miss_dst <= '0;
         r_io_o_data     <= '0;
         r_io_o_valid    <= 1'b0;
         r_retired       <= '0;
         r_flush_cnt     <= '0;
      end else begin
         r_state         <= w_state_next;
         r_reg_we        <= w_reg_we_next;
         r_reg_wr_addr   <= w_reg_wr_addr_next;
         r_reg_wr_data   <= w_reg_wr_data_next;
         r_branch_miss   <= w_branch_miss_next;
         r_pred_miss_dst <= w_pred_miss_dst_next;
         r_io_o_data     <= w_io_o_data_next;
         r_io_o_valid    <= w_io_o_valid_next;
         r_retired       <= w_retired_next;
         r_flush_cnt     <= w_flush_cnt_next;
      end
   end

   assign i_ready       = w_ready;
   assign reg_we        = r_reg_we;
   assign reg_wr_addr   = r_reg_wr_addr;
   assign reg_wr_data   = r_reg_wr_data;
   assign branch_miss   = r_branch_miss;
   assign pred_miss_dst = r_pred_miss_dst;
   assign io_o_data     = r_io_o_data;
   assign io_o_valid    = r_io_o_valid;
   assign retired       = r_retired;

endmodule
